// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine: assembles UART command frames (opcode, operand A, operand B,
// each operand NB_DATA/8 bytes, LSB first), presents them to the ALU for one
// cycle, captures the result and streams it back byte by byte over uart_tx.
// Partial frames are discarded after TIMEOUT_CYC cycles of inter-byte silence.
//
// Optional feature: define UART_CMD_CHECKSUM_EN to expect a trailing XOR
// checksum byte. A bad checksum aborts the frame and answers with 0xEE.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for an opcode byte
// GET_A   | collecting operand A bytes, timeout-guarded
// GET_B   | collecting operand B bytes, timeout-guarded
// GET_CHK | (checksum build only) waiting for the checksum byte
// EXEC    | operands valid to the ALU, result captured
// TX_LOAD | load next outgoing byte and pulse tx start
// TX_WAIT | waiting for uart_tx to finish the current byte

module uart_cmd_engine #(
    parameter int NB_DATA     = 8,
    parameter int NB_OP       = 6,
    parameter int TIMEOUT_CYC = 100000,
    parameter int NB_TIMER    = 17
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [7:0]         i_rx,
    input  logic               i_rxDone,
    input  logic               i_txDone,
    output logic               o_tx_start,
    output logic [7:0]         o_data,
    output logic [NB_OP-1:0]   o_operation,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic               o_valid,
    input  logic [NB_DATA-1:0] i_result,
    output logic               o_frame_err,
    output logic               o_busy
);

    localparam int NBYTES = NB_DATA / 8;
    localparam int NB_CNT = 3;
    localparam logic [NB_CNT-1:0]   LAST_IDX    = NB_CNT'(NBYTES - 1);
    localparam logic [NB_TIMER-1:0] TIMEOUT_VAL = NB_TIMER'(TIMEOUT_CYC);

`ifdef UART_CMD_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_A   = 3'd1,
        GET_B   = 3'd2,
        EXEC    = 3'd3,
        TX_LOAD = 3'd4,
        TX_WAIT = 3'd5,
        GET_CHK = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_A   = 3'd1,
        GET_B   = 3'd2,
        EXEC    = 3'd3,
        TX_LOAD = 3'd4,
        TX_WAIT = 3'd5
    } state_t;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [NB_CNT-1:0]   cnt;
    logic [NB_TIMER-1:0] timer;
    logic [NB_DATA-1:0]  result_q;
    logic                err_tx;
    logic                in_get;
    logic                timeout;
    logic                rx_take;
    logic                last_byte;
    logic                last_tx;
    logic                abort;
    logic [7:0]          tx_byte;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]          chk_acc;
    logic                chk_match;

    assign in_get    = (state == GET_A) || (state == GET_B) || (state == GET_CHK);
    assign chk_match = (i_rx == chk_acc);
`else
    assign in_get    = (state == GET_A) || (state == GET_B);
`endif

    // Timeout has priority over a byte arriving in the same cycle.
    assign timeout   = in_get && (timer == TIMEOUT_VAL);
    assign rx_take   = i_rxDone && !timeout;
    assign last_byte = (cnt == LAST_IDX);
    // An error reply is always a single byte regardless of NBYTES.
    assign last_tx   = err_tx || last_byte;

    assign o_valid = (state == EXEC);
    assign o_busy  = (state != IDLE);

    // Select the result byte addressed by the byte counter.
    always_comb begin
        tx_byte = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (cnt == NB_CNT'(b)) begin
                tx_byte = result_q[b*8 +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and abort detection.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (i_rxDone) begin
                    state_nxt = GET_A;
                end
            end
            GET_A: begin
                if (timeout) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (i_rxDone && last_byte) begin
                    state_nxt = GET_B;
                end
            end
            GET_B: begin
                if (timeout) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (i_rxDone && last_byte) begin
`ifdef UART_CMD_CHECKSUM_EN
                    state_nxt = GET_CHK;
`else
                    state_nxt = EXEC;
`endif
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            GET_CHK: begin
                if (timeout) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end else if (i_rxDone) begin
                    if (chk_match) begin
                        state_nxt = EXEC;
                    end else begin
                        abort     = 1'b1;
                        state_nxt = TX_LOAD;
                    end
                end
            end
`endif
            EXEC: begin
                state_nxt = TX_LOAD;
            end
            TX_LOAD: begin
                state_nxt = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_txDone) begin
                    state_nxt = last_tx ? IDLE : TX_LOAD;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Inter-byte silence timer, running only while collecting a frame.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            timer <= '0;
        end else if (in_get && !i_rxDone && !timeout) begin
            timer <= timer + NB_TIMER'(1);
        end else begin
            timer <= '0;
        end
    end

    // Frame assembly, result capture and transmit sequencing.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_start  <= 1'b0;
            o_data      <= 8'h00;
            o_operation <= '0;
            o_datoA     <= '0;
            o_datoB     <= '0;
            o_frame_err <= 1'b0;
            cnt         <= '0;
            result_q    <= '0;
            err_tx      <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            chk_acc     <= 8'h00;
`endif
        end else begin
            o_tx_start  <= 1'b0;
            o_frame_err <= abort;
            case (state)
                IDLE: begin
                    if (i_rxDone) begin
                        o_operation <= i_rx[NB_OP-1:0];
                        cnt         <= '0;
                        err_tx      <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
                        chk_acc     <= i_rx;
`endif
                    end
                end
                GET_A: begin
                    if (rx_take) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            if (cnt == NB_CNT'(b)) begin
                                o_datoA[b*8 +: 8] <= i_rx;
                            end
                        end
                        cnt <= last_byte ? '0 : cnt + NB_CNT'(1);
`ifdef UART_CMD_CHECKSUM_EN
                        chk_acc <= chk_acc ^ i_rx;
`endif
                    end
                end
                GET_B: begin
                    if (rx_take) begin
                        for (int b = 0; b < NBYTES; b++) begin
                            if (cnt == NB_CNT'(b)) begin
                                o_datoB[b*8 +: 8] <= i_rx;
                            end
                        end
                        cnt <= last_byte ? '0 : cnt + NB_CNT'(1);
`ifdef UART_CMD_CHECKSUM_EN
                        chk_acc <= chk_acc ^ i_rx;
`endif
                    end
                end
`ifdef UART_CMD_CHECKSUM_EN
                GET_CHK: begin
                    if (rx_take && !chk_match) begin
                        err_tx <= 1'b1;
                    end
                end
`endif
                EXEC: begin
                    result_q <= i_result;
                end
                TX_LOAD: begin
                    o_data     <= err_tx ? 8'hEE : tx_byte;
                    o_tx_start <= 1'b1;
                end
                TX_WAIT: begin
                    if (i_txDone) begin
                        cnt <= last_tx ? '0 : cnt + NB_CNT'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed testbench for uart_cmd_engine: an 8-bit instance (u_a) and a 16-bit
// instance (u_b), both with a 50-cycle timeout and an A+B ALU stub.
module tb_uart_cmd_engine;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_err    = 0;

    // 8-bit instance signals
    logic [7:0] a_rx = 8'h00;
    logic       a_rxDone = 1'b0;
    logic       a_txDone = 1'b0;
    logic       a_tx_start;
    logic [7:0] a_data;
    logic [5:0] a_op;
    logic [7:0] a_A, a_B, a_result;
    logic       a_valid, a_frame_err, a_busy;
    assign a_result = a_A + a_B;

    // 16-bit instance signals
    logic [7:0]  b_rx = 8'h00;
    logic        b_rxDone = 1'b0;
    logic        b_txDone = 1'b0;
    logic        b_tx_start;
    logic [7:0]  b_data;
    logic [5:0]  b_op;
    logic [15:0] b_A, b_B, b_result;
    logic        b_valid, b_frame_err, b_busy;
    assign b_result = b_A + b_B;

    uart_cmd_engine #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYC(50), .NB_TIMER(6)) u_a (
        .clk(clk), .i_rst_n(rst_n), .i_rx(a_rx), .i_rxDone(a_rxDone), .i_txDone(a_txDone),
        .o_tx_start(a_tx_start), .o_data(a_data), .o_operation(a_op), .o_datoA(a_A),
        .o_datoB(a_B), .o_valid(a_valid), .i_result(a_result), .o_frame_err(a_frame_err),
        .o_busy(a_busy));

    uart_cmd_engine #(.NB_DATA(16), .NB_OP(6), .TIMEOUT_CYC(50), .NB_TIMER(6)) u_b (
        .clk(clk), .i_rst_n(rst_n), .i_rx(b_rx), .i_rxDone(b_rxDone), .i_txDone(b_txDone),
        .o_tx_start(b_tx_start), .o_data(b_data), .o_operation(b_op), .o_datoA(b_A),
        .o_datoB(b_B), .o_valid(b_valid), .i_result(b_result), .o_frame_err(b_frame_err),
        .o_busy(b_busy));

    // Pulse monitors, sampled on the falling edge.
    int         a_valid_n = 0, a_start_n = 0, a_err_n = 0;
    logic [7:0] a_tx [0:63];
    logic [5:0] a_op_cap;
    logic [7:0] a_A_cap, a_B_cap;
    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            a_valid_n++; a_op_cap = a_op; a_A_cap = a_A; a_B_cap = a_B;
        end
        if (a_tx_start === 1'b1) begin
            a_tx[a_start_n % 64] = a_data; a_start_n++;
        end
        if (a_frame_err === 1'b1) a_err_n++;
    end

    int          b_valid_n = 0, b_start_n = 0, b_err_n = 0;
    logic [7:0]  b_tx [0:63];
    int          b_start_cyc [0:63];
    logic [15:0] b_A_cap, b_B_cap;
    always @(negedge clk) begin
        if (b_valid === 1'b1) begin
            b_valid_n++; b_A_cap = b_A; b_B_cap = b_B;
        end
        if (b_tx_start === 1'b1) begin
            b_tx[b_start_n % 64] = b_data; b_start_cyc[b_start_n % 64] = cyc; b_start_n++;
        end
        if (b_frame_err === 1'b1) b_err_n++;
    end

    // uart_tx models: answer each tx start with txDone a few cycles later,
    // unless held off; a reset during the hold abandons the byte.
    bit a_hold = 1'b0;
    always begin
        @(negedge clk);
        if (a_tx_start === 1'b1) begin
            repeat (4) @(posedge clk);
            while (a_hold && rst_n) @(posedge clk);
            if (rst_n) begin
                #1 a_txDone = 1'b1;
                @(posedge clk);
                #1 a_txDone = 1'b0;
            end
        end
    end

    bit b_hold = 1'b0;
    int b_done_cyc [0:63];
    int b_done_n = 0;
    always begin
        @(negedge clk);
        if (b_tx_start === 1'b1) begin
            repeat (4) @(posedge clk);
            while (b_hold && rst_n) @(posedge clk);
            if (rst_n) begin
                #1 b_txDone = 1'b1;
                b_done_cyc[b_done_n % 64] = cyc;
                b_done_n++;
                @(posedge clk);
                #1 b_txDone = 1'b0;
            end
        end
    end

    task automatic send_a(input logic [7:0] v);
        @(posedge clk); #1;
        a_rx = v; a_rxDone = 1'b1;
        @(posedge clk); #1;
        a_rxDone = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] v);
        @(posedge clk); #1;
        b_rx = v; b_rxDone = 1'b1;
        @(posedge clk); #1;
        b_rxDone = 1'b0;
    endtask

    task automatic frame_a(input logic [7:0] op, input logic [7:0] x, input logic [7:0] y);
        send_a(op); send_a(x); send_a(y);
`ifdef UART_CMD_CHECKSUM_EN
        send_a(op ^ x ^ y);
`endif
    endtask

    task automatic frame_b(input logic [7:0] op, input logic [15:0] x, input logic [15:0] y);
        send_b(op); send_b(x[7:0]); send_b(x[15:8]); send_b(y[7:0]); send_b(y[15:8]);
`ifdef UART_CMD_CHECKSUM_EN
        send_b(op ^ x[7:0] ^ x[15:8] ^ y[7:0] ^ y[15:8]);
`endif
    endtask

    task automatic wait_idle_a(input string name);
        for (int i = 0; i < 300 && a_busy !== 1'b0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (a_busy !== 1'b0) begin n_err++; $display("FAIL %s idle_a: busy=%b expected 0", name, a_busy); end
    endtask

    task automatic wait_idle_b(input string name);
        for (int i = 0; i < 400 && b_busy !== 1'b0; i++) @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (b_busy !== 1'b0) begin n_err++; $display("FAIL %s idle_b: busy=%b expected 0", name, b_busy); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if ({a_tx_start, a_data, a_op, a_A, a_B, a_valid, a_frame_err, a_busy} !== 0) begin
            n_err++; $display("FAIL reset_a: outputs=%h expected 0",
                              {a_tx_start, a_data, a_op, a_A, a_B, a_valid, a_frame_err, a_busy});
        end
        n_checks++;
        if ({b_tx_start, b_data, b_op, b_A, b_B, b_valid, b_frame_err, b_busy} !== 0) begin
            n_err++; $display("FAIL reset_b: outputs=%h expected 0",
                              {b_tx_start, b_data, b_op, b_A, b_B, b_valid, b_frame_err, b_busy});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        n_checks++;
        if (a_busy !== 1'b0) begin n_err++; $display("FAIL reset_release: busy=%b expected 0", a_busy); end
    endtask

    task automatic test_basic8;
        int vb, sb, eb;
        vb = a_valid_n; sb = a_start_n; eb = a_err_n;
        frame_a(8'h20, 8'h05, 8'h03);
        n_checks++;
        if (a_valid !== 1'b1) begin n_err++; $display("FAIL basic8_latency: valid=%b expected 1", a_valid); end
        wait_idle_a("basic8");
        n_checks++;
        if (a_valid_n - vb !== 1) begin n_err++; $display("FAIL basic8_valid_cnt: got %0d expected 1", a_valid_n - vb); end
        n_checks++;
        if ({a_op_cap, a_A_cap, a_B_cap} !== {6'h20, 8'h05, 8'h03}) begin
            n_err++; $display("FAIL basic8_operands: op=%h A=%h B=%h expected 20 05 03", a_op_cap, a_A_cap, a_B_cap);
        end
        n_checks++;
        if (a_start_n - sb !== 1) begin n_err++; $display("FAIL basic8_tx_cnt: got %0d expected 1", a_start_n - sb); end
        n_checks++;
        if (a_tx[sb % 64] !== 8'h08) begin n_err++; $display("FAIL basic8_tx_byte: got %h expected 08", a_tx[sb % 64]); end
        n_checks++;
        if (a_err_n - eb !== 0) begin n_err++; $display("FAIL basic8_no_err: got %0d expected 0", a_err_n - eb); end
    endtask

    task automatic test_multi16;
        int sb, db, vb;
        sb = b_start_n; db = b_done_n; vb = b_valid_n;
        frame_b(8'h20, 16'h1234, 16'h0001);
        n_checks++;
        if (b_valid !== 1'b1) begin n_err++; $display("FAIL multi16_latency: valid=%b expected 1", b_valid); end
        wait_idle_b("multi16");
        n_checks++;
        if (b_valid_n - vb !== 1) begin n_err++; $display("FAIL multi16_valid_cnt: got %0d expected 1", b_valid_n - vb); end
        n_checks++;
        if ({b_A_cap, b_B_cap} !== {16'h1234, 16'h0001}) begin
            n_err++; $display("FAIL multi16_operands: A=%h B=%h expected 1234 0001", b_A_cap, b_B_cap);
        end
        n_checks++;
        if (b_start_n - sb !== 2) begin n_err++; $display("FAIL multi16_tx_cnt: got %0d expected 2", b_start_n - sb); end
        n_checks++;
        if ({b_tx[sb % 64], b_tx[(sb + 1) % 64]} !== 16'h3512) begin
            n_err++; $display("FAIL multi16_tx_bytes: got %h %h expected 35 12", b_tx[sb % 64], b_tx[(sb + 1) % 64]);
        end
        n_checks++;
        if (!(b_start_cyc[(sb + 1) % 64] > b_done_cyc[db % 64])) begin
            n_err++; $display("FAIL multi16_tx_order: second start cyc %0d, first done cyc %0d, expected start after done",
                              b_start_cyc[(sb + 1) % 64], b_done_cyc[db % 64]);
        end
    endtask

    task automatic test_timeout;
        int vb, eb, sb;
        vb = a_valid_n; eb = a_err_n; sb = a_start_n;
        send_a(8'h20);
        send_a(8'h05);
        repeat (45) @(posedge clk); #1;
        n_checks++;
        if (a_busy !== 1'b1 || a_err_n - eb !== 0) begin
            n_err++; $display("FAIL timeout_early: busy=%b errs=%0d expected busy=1 errs=0", a_busy, a_err_n - eb);
        end
        repeat (15) @(posedge clk); #1;
        n_checks++;
        if (a_err_n - eb !== 1) begin n_err++; $display("FAIL timeout_err_cnt: got %0d expected 1", a_err_n - eb); end
        n_checks++;
        if (a_valid_n - vb !== 0 || a_busy !== 1'b0) begin
            n_err++; $display("FAIL timeout_discard: valids=%0d busy=%b expected 0 0", a_valid_n - vb, a_busy);
        end
        frame_a(8'h20, 8'h01, 8'h01);
        wait_idle_a("timeout_next");
        n_checks++;
        if (a_start_n - sb !== 1 || a_tx[sb % 64] !== 8'h02) begin
            n_err++; $display("FAIL timeout_next_tx: count=%0d byte=%h expected 1 02", a_start_n - sb, a_tx[sb % 64]);
        end
    endtask

    task automatic test_rx_during_tx;
        int vb, sb;
        vb = a_valid_n; sb = a_start_n;
        a_hold = 1'b1;
        frame_a(8'h20, 8'h05, 8'h03);
        for (int i = 0; i < 50 && a_tx_start !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (a_tx_start !== 1'b1) begin n_err++; $display("FAIL rxtx_start_seen: tx_start=%b expected 1", a_tx_start); end
        send_a(8'h99);
        repeat (2) @(posedge clk);
        a_hold = 1'b0;
        wait_idle_a("rxtx");
        n_checks++;
        if (a_start_n - sb !== 1 || a_valid_n - vb !== 1) begin
            n_err++; $display("FAIL rxtx_dropped: tx=%0d valids=%0d expected 1 1", a_start_n - sb, a_valid_n - vb);
        end
        frame_a(8'hD1, 8'h07, 8'h02);
        wait_idle_a("rxtx_next");
        n_checks++;
        if ({a_op_cap, a_A_cap, a_B_cap} !== {6'h11, 8'h07, 8'h02}) begin
            n_err++; $display("FAIL rxtx_next_operands: op=%h A=%h B=%h expected 11 07 02", a_op_cap, a_A_cap, a_B_cap);
        end
        n_checks++;
        if (a_start_n - sb !== 2 || a_tx[(sb + 1) % 64] !== 8'h09) begin
            n_err++; $display("FAIL rxtx_next_tx: count=%0d byte=%h expected 2 09", a_start_n - sb, a_tx[(sb + 1) % 64]);
        end
    endtask

    task automatic test_reset_mid_tx;
        int sb;
        sb = b_start_n;
        b_hold = 1'b1;
        frame_b(8'h20, 16'h0010, 16'h0005);
        for (int i = 0; i < 50 && b_tx_start !== 1'b1; i++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({b_tx_start, b_data, b_op, b_A, b_B, b_valid, b_frame_err, b_busy} !== 0) begin
            n_err++; $display("FAIL rstmid_outputs: outputs=%h expected 0",
                              {b_tx_start, b_data, b_op, b_A, b_B, b_valid, b_frame_err, b_busy});
        end
        repeat (6) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk); #1;
        n_checks++;
        if (b_start_n - sb !== 1 || b_busy !== 1'b0) begin
            n_err++; $display("FAIL rstmid_abandon: tx=%0d busy=%b expected 1 0", b_start_n - sb, b_busy);
        end
        n_checks++;
        if (b_tx[sb % 64] !== 8'h15) begin n_err++; $display("FAIL rstmid_first_byte: got %h expected 15", b_tx[sb % 64]); end
        b_hold = 1'b0;
        frame_b(8'h01, 16'h0102, 16'h0203);
        wait_idle_b("rstmid_next");
        n_checks++;
        if (b_start_n - sb !== 3 || {b_tx[(sb + 1) % 64], b_tx[(sb + 2) % 64]} !== 16'h0503) begin
            n_err++; $display("FAIL rstmid_next_tx: count=%0d bytes=%h %h expected 3 05 03",
                              b_start_n - sb, b_tx[(sb + 1) % 64], b_tx[(sb + 2) % 64]);
        end
    endtask

`ifdef UART_CMD_CHECKSUM_EN
    task automatic test_checksum;
        int vb, sb, eb;
        vb = a_valid_n; sb = a_start_n; eb = a_err_n;
        send_a(8'h20); send_a(8'h05); send_a(8'h03); send_a(8'h26);
        wait_idle_a("chk_good");
        n_checks++;
        if (a_valid_n - vb !== 1 || a_start_n - sb !== 1 || a_tx[sb % 64] !== 8'h08) begin
            n_err++; $display("FAIL chk_good: valids=%0d tx=%0d byte=%h expected 1 1 08",
                              a_valid_n - vb, a_start_n - sb, a_tx[sb % 64]);
        end
        send_a(8'h20); send_a(8'h05); send_a(8'h03); send_a(8'h00);
        wait_idle_a("chk_bad");
        n_checks++;
        if (a_err_n - eb !== 1 || a_valid_n - vb !== 1) begin
            n_err++; $display("FAIL chk_bad_flags: errs=%0d valids=%0d expected 1 1", a_err_n - eb, a_valid_n - vb);
        end
        n_checks++;
        if (a_start_n - sb !== 2 || a_tx[(sb + 1) % 64] !== 8'hEE) begin
            n_err++; $display("FAIL chk_bad_tx: count=%0d byte=%h expected 2 EE", a_start_n - sb, a_tx[(sb + 1) % 64]);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic8();
        test_multi16();
        test_timeout();
        test_rx_during_tx();
        test_reset_mid_tx();
`ifdef UART_CMD_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_cmd_engine.md
Name: uart_cmd_engine

Overview:
Parametrised successor to the UART-to-ALU interface. Sits between uart_rx/uart_tx and the ALU, and assembles multi-byte command frames: one opcode byte, then operand A, then operand B, each operand NB_DATA/8 bytes, LSB first. It presents one operand set to the ALU, captures the result, and serialises it back over uart_tx. Adds an inter-byte timeout with frame discard and a busy/error status that the single-byte interface lacks.

Parameters:
NB_DATA, 8, ALU operand/result width; must be a multiple of 8 in the range 8..32; NBYTES = NB_DATA/8
NB_OP, 6, opcode width; taken from the low NB_OP bits of the opcode byte
TIMEOUT_CYC, 100000, clk cycles of inter-byte silence that abort a partial frame
NB_TIMER, 17, timeout counter width; must satisfy 2^NB_TIMER > TIMEOUT_CYC

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset; asynchronous, active-low
i_rx  in  8  received byte from uart_rx; valid when i_rxDone=1
i_rxDone  in  1  one-cycle pulse, byte received
i_txDone  in  1  one-cycle pulse, uart_tx finished the current byte
o_tx_start  out  1  one-cycle pulse, start transmitting o_data
o_data  out  8  byte to transmit; held stable from o_tx_start until i_txDone
o_operation  out  NB_OP  opcode to ALU
o_datoA  out  NB_DATA  operand A to ALU
o_datoB  out  NB_DATA  operand B to ALU
o_valid  out  1  one-cycle pulse, operands valid
i_result  in  NB_DATA  combinational ALU result
o_frame_err  out  1  one-cycle pulse, frame aborted
o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset: asynchronous on i_rst_n low. State returns to IDLE; all outputs, the byte counter, the timer and the result register clear to 0. Reset mid-frame or mid-TX abandons the operation with no further tx_start.
- States: IDLE, GET_A, GET_B, [GET_CHK], EXEC, TX_LOAD, TX_WAIT.
- IDLE: on i_rxDone, o_operation <= i_rx[NB_OP-1:0]; byte counter <= 0; go to GET_A.
- GET_A / GET_B: each i_rxDone writes i_rx into byte[cnt] of the operand (LSB first) and increments cnt. After NBYTES bytes, cnt returns to 0 and the state advances: GET_A -> GET_B -> EXEC, or GET_B -> GET_CHK when checksum is enabled.
- Timer: cleared on entry to GET_* and on every i_rxDone; increments each clk while in GET_*. When it reaches TIMEOUT_CYC: o_frame_err pulses for 1 cycle, state goes to IDLE, and o_valid is not asserted. The partial operand registers keep their garbage; this is permitted.
- EXEC: o_valid=1 for exactly one cycle. On the same edge the result register captures i_result. Next state is TX_LOAD.
- Latency: o_valid is asserted in the cycle after the final operand byte's i_rxDone.
- TX_LOAD: o_data <= result byte[cnt]; o_tx_start=1 for one cycle; go to TX_WAIT.
- TX_WAIT: on i_txDone, if cnt==NBYTES-1 go to IDLE, else increment cnt and go to TX_LOAD.
- i_rxDone in EXEC/TX_*: the byte is dropped with no side effect.
- i_rxDone in the cycle the timer expires: timeout wins and the byte is dropped.
- o_operation/o_datoA/o_datoB hold their last values between frames.

Optional Feature:
UART_CMD_CHECKSUM_EN:
- When defined: the frame carries one extra trailing byte in state GET_CHK, which is also timeout-guarded. The byte must equal the XOR of the opcode byte and all operand bytes.
- Checksum match: continue to EXEC.
- Checksum mismatch: o_frame_err pulses, o_valid is suppressed, and a single byte 0xEE is transmitted (TX_LOAD/TX_WAIT with NBYTES forced to 1), then IDLE.
- When undefined: GET_CHK does not exist and the frame is opcode + 2*NBYTES bytes.

Test Plan:
- NB_DATA=8, ALU stub returns A+B; rx 0x20,0x05,0x03 -> one o_valid pulse with op=0x20, A=0x05, B=0x03; exactly one o_tx_start with o_data=0x08; o_busy back to 0 after i_txDone.
- NB_DATA=16; rx 0x20,0x34,0x12,0x01,0x00 -> A=0x1234, B=0x0001; TX 0x35 then 0x12, the second o_tx_start only after the first i_txDone.
- TIMEOUT_CYC=50; rx 0x20,0x05, then 51 idle cycles -> o_frame_err pulses once, no o_valid; a following full frame 0x20,0x01,0x01 returns 0x02.
- During TX_WAIT inject i_rxDone with 0x99 -> the byte is ignored and the next frame decodes correctly.
- Assert i_rst_n=0 between o_tx_start and i_txDone -> all outputs 0 immediately, no further o_tx_start, IDLE after release.
- With UART_CMD_CHECKSUM_EN: rx 0x20,0x05,0x03 then chk 0x26 -> TX 0x08; with chk 0x00 instead -> o_frame_err pulse, no o_valid, TX 0xEE.
